// File: rtl/uart_pkg.sv
// Shared UART types: transmit FSM encoding, parity modes, word-length codes.
// Pure declarations; no timing or handshake behaviour lives here.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_TX_IDLE   = 3'd0,
        UART_TX_START  = 3'd1,
        UART_TX_DATA   = 3'd2,
        UART_TX_PARITY = 3'd3,
        UART_TX_STOP1  = 3'd4,
        UART_TX_STOP2  = 3'd5
    } uart_tx_state_e;

    typedef enum logic [1:0] {
        UART_PAR_NONE = 2'b00,
        UART_PAR_EVEN = 2'b01,
        UART_PAR_ODD  = 2'b10
    } uart_parity_e;

    localparam logic [1:0] UART_WL_5 = 2'b00;
    localparam logic [1:0] UART_WL_6 = 2'b01;
    localparam logic [1:0] UART_WL_7 = 2'b10;
    localparam logic [1:0] UART_WL_8 = 2'b11;

    localparam int UART_MIN_DATA_BITS = 5;

    // Word length in bits, clamped to what the instance can actually carry.
    function automatic logic [3:0] uart_word_len(input logic [1:0] code,
                                                 input logic [3:0] max_bits);
        logic [3:0] len;
        len = 4'(UART_MIN_DATA_BITS) + {2'b00, code};
        return (len > max_bits) ? max_bits : len;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div per bit, flags the last cycle of each bit.
// Latency: bclk registered, pulses on the first cycle of every bit; no backpressure.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 pclk,
    input  logic                 areset,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 active_i,
    input  logic                 frame_end_i,
    output logic                 tick_o,
    output logic                 bclk_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 bclk_q, bclk_d;

    assign tick_o = active_i && (cnt_q == div_q);
    assign bclk_o = bclk_q;

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (load_i) begin
            div_d = div_i;
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (active_i) begin
            cnt_d = cnt_q + 1'b1;
        end
        // A new bit starts after acceptance or after any wrap that is not the frame's last.
        bclk_d = load_i | (tick_o & ~frame_end_i);
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            cnt_q  <= '0;
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start, 5..8 data bits LSB first, optional parity (UART_TX_PARITY_EN), 1/2 stops.
// Latency: tx falls one pclk after acceptance; tx_ready low for the whole frame, so tx_valid simply waits.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [1:0]            data_bits,
    input  logic                  stop2,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]            parity_mode,
`endif
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  bclk,
    output logic                  busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = UART_TX_IDLE;
    localparam logic [2:0] S_START  = UART_TX_START;
    localparam logic [2:0] S_DATA   = UART_TX_DATA;
    localparam logic [2:0] S_PARITY = UART_TX_PARITY;
    localparam logic [2:0] S_STOP1  = UART_TX_STOP1;
    localparam logic [2:0] S_STOP2  = UART_TX_STOP2;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [BW-1:0]         last_q, last_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic                  tick;
    logic                  frame_end;
    logic [3:0]            len_w;

`ifdef UART_TX_PARITY_EN
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [DATA_WIDTH-1:0] par_mask;
`endif

    assign accept = (state_q == S_IDLE) && tx_valid;
    assign len_w  = uart_word_len(data_bits, 4'(DATA_WIDTH));

`ifdef UART_TX_PARITY_EN
    always_comb begin
        par_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            par_mask[i] = (4'(i) < len_w);
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_d     = bit_q;
        last_d    = last_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        frame_end = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    data_d  = tx_data;
                    last_d  = BW'(len_w - 4'd1);
                    stop2_d = stop2;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = (parity_mode == UART_PAR_EVEN) || (parity_mode == UART_PAR_ODD);
                    par_bit_d = (^(tx_data & par_mask)) ^ (parity_mode == UART_PAR_ODD);
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == last_q) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP1;
                            tx_d    = 1'b1;
                        end
`else
                        state_d = S_STOP1;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        data_d = data_q >> 1;
                        tx_d   = data_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP1;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP1: begin
                if (tick) begin
                    tx_d = 1'b1;
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d   = S_IDLE;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        frame_end = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (tick) begin
                    state_d   = S_IDLE;
                    tx_d      = 1'b1;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            bit_q     <= '0;
            last_q    <= '0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_q     <= bit_d;
            last_q    <= last_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .pclk        (pclk),
        .areset      (areset),
        .load_i      (accept),
        .div_i       (baud_div),
        .active_i    (busy_q),
        .frame_end_i (frame_end),
        .tick_o      (tick),
        .bclk_o      (bclk)
    );

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine; expected per-cycle tx/bclk come from a frame model queue.
module tb_uart_tx_engine;

    localparam int DW  = 8;
    localparam int DVW = 16;

    logic           pclk = 1'b0;
    logic           areset;
    logic [DVW-1:0] baud_div;
    logic [1:0]     data_bits;
    logic           stop2;
`ifdef UART_TX_PARITY_EN
    logic [1:0]     parity_mode;
`endif
    logic           tx_valid;
    logic [DW-1:0]  tx_data;
    logic           tx_ready;
    logic           tx;
    logic           bclk;
    logic           busy;

    typedef struct packed {
        logic tx;
        logic bclk;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   busy_cnt = 0;
    int   bclk_cnt = 0;

    always #5 pclk = ~pclk;

    uart_tx_engine #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (DVW)
    ) dut (
        .pclk        (pclk),
        .areset      (areset),
        .baud_div    (baud_div),
        .data_bits   (data_bits),
        .stop2       (stop2),
`ifdef UART_TX_PARITY_EN
        .parity_mode (parity_mode),
`endif
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx          (tx),
        .bclk        (bclk),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, n data bits LSB first, parity (1=even, 2=odd), stop(s).
    function automatic void push_frame(input logic [7:0] d, input int n, input bit s2,
                                       input int pm, input int div);
        logic bq[$];
        logic p;
        exp_t e;
        p = 1'b0;
        bq.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bq.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pm == 1) bq.push_back(p);
        if (pm == 2) bq.push_back(~p);
        bq.push_back(1'b1);
        if (s2) bq.push_back(1'b1);
        foreach (bq[b]) begin
            for (int c = 0; c <= div; c++) begin
                e.tx   = bq[b];
                e.bclk = (c == 0);
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic start_word(input logic [7:0] d, input logic [1:0] code, input bit s2,
                              input int pm, input int div, input bit hold);
        bit seen;
        tx_data   = d;
        data_bits = code;
        stop2     = s2;
        baud_div  = DVW'(div);
`ifdef UART_TX_PARITY_EN
        parity_mode = 2'(pm);
`endif
        tx_valid  = 1'b1;
        push_frame(d, 5 + int'(code), s2, pm, div);
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge pclk);
            if (tx_ready === 1'b1) seen = 1'b1;
        end
        chk("ready_wait", {31'd0, seen}, 32'd1);
        @(posedge pclk);
        #1;
        busy_cnt = 0;
        bclk_cnt = 0;
        if (!hold) begin
            // Scramble inputs: the frame in flight must use the latched copies.
            tx_valid  = 1'b0;
            tx_data   = DW'($urandom);
            data_bits = 2'($urandom);
            stop2     = 1'($urandom);
            baud_div  = DVW'($urandom_range(0, 7));
`ifdef UART_TX_PARITY_EN
            parity_mode = 2'($urandom);
`endif
        end
    endtask

    task automatic check_cycles(input int ncyc, input string tag);
        exp_t e;
        for (int i = 0; i < ncyc && exp_q.size() > 0; i++) begin
            @(negedge pclk);
            e = exp_q.pop_front();
            chk($sformatf("%s_tx[%0d]", tag, i), {31'd0, tx}, {31'd0, e.tx});
            chk($sformatf("%s_bclk[%0d]", tag, i), {31'd0, bclk}, {31'd0, e.bclk});
            chk($sformatf("%s_busy[%0d]", tag, i), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_ready[%0d]", tag, i), {31'd0, tx_ready}, 32'd0);
            busy_cnt += int'(busy);
            bclk_cnt += int'(bclk);
        end
    endtask

    task automatic idle_check(input string tag, input int exp_len, input int exp_bits);
        @(negedge pclk);
        chk({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, tx_ready}, 32'd1);
        chk({tag, "_idle_bclk"}, {31'd0, bclk}, 32'd0);
        chk({tag, "_frame_len"}, busy_cnt, exp_len);
        chk({tag, "_bclk_count"}, bclk_cnt, exp_bits);
    endtask

    initial begin
        areset    = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        data_bits = 2'b11;
        stop2     = 1'b0;
        baud_div  = '0;
`ifdef UART_TX_PARITY_EN
        parity_mode = 2'b00;
`endif
        repeat (2) @(negedge pclk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_bclk", {31'd0, bclk}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        areset = 1'b1;

        // 8N1 0xA5, 4 pclk per bit
        start_word(8'hA5, 2'b11, 1'b0, 0, 3, 1'b0);
        check_cycles(100000, "a5");
        idle_check("a5", 40, 10);

        // 5-bit 0xFF, two stops: upper data bits must not appear
`ifdef UART_TX_PARITY_EN
        start_word(8'hFF, 2'b00, 1'b1, 2, 1, 1'b0);
        check_cycles(100000, "5o2");
        idle_check("5o2", 18, 9);

        start_word(8'h07, 2'b11, 1'b0, 1, 0, 1'b0);
        check_cycles(100000, "8e1");
        idle_check("8e1", 11, 11);
`else
        start_word(8'hFF, 2'b00, 1'b1, 0, 1, 1'b0);
        check_cycles(100000, "5n2");
        idle_check("5n2", 16, 8);
`endif

        // 7-bit word: bit 7 set must be dropped
        start_word(8'h80, 2'b10, 1'b0, 0, 0, 1'b0);
        check_cycles(100000, "7n1");
        idle_check("7n1", 9, 9);

        // Back-to-back with tx_valid held: one idle-high pclk between frames
        start_word(8'h55, 2'b11, 1'b0, 0, 1, 1'b1);
        tx_data = 8'hAA;
        push_frame(8'hAA, 8, 1'b0, 0, 1);
        check_cycles(20, "b2b_55");
        idle_check("b2b_55", 20, 10);
        @(posedge pclk);
        #1;
        tx_valid = 1'b0;
        busy_cnt = 0;
        bclk_cnt = 0;
        check_cycles(20, "b2b_aa");
        idle_check("b2b_aa", 20, 10);

        // Reset asserted in the middle of the data bits of 0x3C
        start_word(8'h3C, 2'b11, 1'b0, 0, 3, 1'b0);
        check_cycles(12, "rst_mid");
        #2;
        areset = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("mid_rst_bclk", {31'd0, bclk}, 32'd0);
        exp_q.delete();
        @(negedge pclk);
        areset = 1'b1;

        // Clean frame after reset release
        start_word(8'h81, 2'b11, 1'b0, 0, 2, 1'b0);
        check_cycles(100000, "x81");
        idle_check("x81", 30, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
